// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, widths and helpers for the data cache controller.
// Holds the FSM state enum, default geometry widths and the counter width.
package dcache_pkg;

  localparam int unsigned CNT_W     = 16;

  localparam int unsigned LINES_DEF = 8;
  localparam int unsigned WORDS_DEF = 4;
  localparam int unsigned AW_DEF    = 16;
  localparam int unsigned DW_DEF    = 16;

  localparam int unsigned OFF_W = $clog2(WORDS_DEF);
  localparam int unsigned IDX_W = $clog2(LINES_DEF);
  localparam int unsigned TAG_W = AW_DEF - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag, valid and data storage for the direct-mapped cache.
// Ports: clk/rst, combinational read (rd_*), word write (wr_*), tag/valid write (tv_*).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned TW    = TAG_W,
  localparam int unsigned IW   = $clog2(LINES),
  localparam int unsigned OW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  input  logic [OW-1:0] rd_off,
  output logic [TW-1:0] rd_tag,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [OW-1:0] wr_off,
  input  logic [DW-1:0] wr_data,
  input  logic          tv_en,
  input  logic [IW-1:0] tv_idx,
  input  logic [TW-1:0] tv_tag,
  input  logic          tv_valid
);

  logic [DW-1:0]    data_q [LINES][WORDS];
  logic [TW-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tv_en) begin
      valid_q[tv_idx] <= tv_valid;
    end
  end

  // Payload storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
    if (tv_en) begin
      tag_q[tv_idx] <= tv_tag;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate D-cache controller.
// Ports: pipeline side (re/we/addr/wdata/rdata/stall), memory side (mem_*), perf counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned OW = $clog2(WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - OW - IW;
  localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

  state_e           state_q;
  logic [OW-1:0]    cnt_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic             refill_q;

  logic [AW-1:0] lk_addr;
  logic [OW-1:0] lk_off;
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic [TW-1:0] rd_tag;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          hit;
  logic [OW-1:0] cnt_nx;

  logic          wr_en;
  logic [OW-1:0] wr_off;
  logic [DW-1:0] wr_data;
  logic          tv_en;
  logic          tv_valid;

  // Outside IDLE the lookup follows the held memory address, so
  // fills and store-hit updates target the transaction's line.
  assign lk_addr = (state_q == IDLE) ? addr : mem_addr_q;
  assign lk_off  = lk_addr[OW-1:0];
  assign lk_idx  = lk_addr[OW +: IW];
  assign lk_tag  = lk_addr[AW-1 -: TW];
  assign hit     = rd_valid && (rd_tag == lk_tag);
  assign cnt_nx  = cnt_q + 1'b1;

  assign rdata     = rd_data;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .DW    (DW),
    .TW    (TW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lk_idx),
    .rd_off   (lk_off),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (lk_idx),
    .wr_off   (wr_off),
    .wr_data  (wr_data),
    .tv_en    (tv_en),
    .tv_idx   (lk_idx),
    .tv_tag   (lk_tag),
    .tv_valid (tv_valid)
  );

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:        stall = we || (re && !hit);
        FILL, WRITE: stall = 1'b1;
        default:     stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_off   = cnt_q;
    wr_data  = mem_rdata;
    tv_en    = 1'b0;
    tv_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // Invalidate up front so a half-filled line never hits.
          tv_en = !we && re && !hit;
        end
        FILL: begin
          wr_en    = mem_ack;
          tv_en    = mem_ack && (cnt_q == LAST);
          tv_valid = 1'b1;
        end
        WRITE: begin
          wr_en   = mem_ack && hit;
          wr_off  = lk_off;
          wr_data = mem_wdata_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      refill_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          refill_q <= 1'b0;
          if (we) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
            state_q     <= WRITE;
          end else if (re && hit) begin
            // The replayed load after a fill was already a miss.
            if (!refill_q) hit_cnt_q <= sat_inc(hit_cnt_q);
          end else if (re) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {lk_tag, lk_idx, {OW{1'b0}}};
            cnt_q      <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (cnt_q != LAST) begin
              cnt_q      <= cnt_nx;
              mem_addr_q <= {mem_addr_q[AW-1:OW], cnt_nx};
            end else begin
              mem_req_q <= 1'b0;
              refill_q  <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller. It sits directly downstream of the MEM pipeline stage, between the stage's load/store port and a multi-cycle unified main memory. Read hits complete in the same cycle. Misses and all stores raise `stall` toward the pipeline until the memory handshake finishes. Hit and miss counts are exposed for performance debug.

## Interface
Parameters:
- `LINES`, 8: number of cache lines; power of two.
- `WORDS`, 4: 16-bit words per line; power of two.
- `AW`, 16: word-address width.
- `DW`, 16: data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `re`  in  1  load request from MEM stage.
- `we`  in  1  store request from MEM stage.
- `addr`  in  AW  word address.
- `wdata`  in  DW  store data.
- `rdata`  out  DW  load data; combinational, valid when `re && !stall`.
- `stall`  out  1  combinational; freezes the pipeline while high.
- `mem_req`  out  1  registered memory request.
- `mem_we`  out  1  registered; 1 = write, 0 = read.
- `mem_addr`  out  AW  registered.
- `mem_wdata`  out  DW  registered.
- `mem_rdata`  in  DW  valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion pulse.
- `hit_cnt`  out  16  saturating load-hit counter.
- `miss_cnt`  out  16  saturating load-miss counter.

## Operation
- Address split: offset = `addr[log2(WORDS)-1:0]`; index = the next log2(LINES) bits; tag = the remaining upper bits (11 bits at defaults).
- `hit` = `valid[index] && tag_mem[index]==tag`.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE transitions:
  - `we` (has priority over `re`): stall=1. Load `mem_req`=1, `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=`wdata`. Go to WRITE.
  - `re` and hit: stall=0; `rdata` = the addressed word; `hit_cnt`++.
  - `re` and miss: stall=1; `miss_cnt`++. Load `mem_req`=1, `mem_we`=0, `mem_addr`={tag,index,0}, word counter `cnt`=0. Clear `valid[index]`. Go to FILL.
  - No request: stall=0.
- FILL: stall=1. On `mem_ack`:
  - Write `mem_rdata` into word `cnt` of the line.
  - If `cnt`≠WORDS-1: `cnt`++ and set `mem_addr`={tag,index,cnt+1}. `mem_req` stays high.
  - Otherwise: write the tag, set `valid[index]`, drop `mem_req`, go to IDLE. The load then re-evaluates as a hit.
- WRITE: stall=1. On `mem_ack`:
  - If the line hits, update the cached word with the held `wdata`.
  - Drop `mem_req` and `mem_we`; go to DONE.
- DONE: stall=0 for exactly one cycle so the pipeline advances past the store. No new request is accepted. Go to IDLE.
- A write miss never allocates a line.
- Counters saturate at 16'hFFFF and do not wrap.
- A re-evaluated hit after a fill does not increment `hit_cnt`; it is already counted as a miss.
- The FSM state enum has no illegal encoding; any unused encoding returns to IDLE.

## Timing
- Reset (synchronous, with `rst` high at the edge):
  - State = IDLE; all valid bits, `cnt`, `hit_cnt` and `miss_cnt` cleared.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `stall` forced to 0 while `rst` is high.
- Reset mid-FILL or mid-WRITE abandons the transaction. The memory must tolerate `mem_req` falling before `mem_ack`. A late `mem_ack` arriving in IDLE is ignored.
- Memory handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 until `mem_ack`.
  - A back-to-back fill word presents its new address in the cycle after the ack.
- With memory latency L (ack in the L-th cycle of a request):
  - Read hit: 0 stall cycles.
  - Read miss: 1 + WORDS·L stall cycles, then a hit cycle.
  - Store: 1 + L stall cycles, then the DONE cycle.
- `mem_ack` outside FILL or WRITE is ignored.
- Data array writes during FILL never change `rdata` of the current stalled load until the line becomes valid.

## Structure
- `dcache_pkg` holds:
  - the state enum (`IDLE`, `FILL`, `WRITE`, `DONE`);
  - localparams for offset, index and tag widths derived from the parameters;
  - the counter width (16).
- Sub-module `dcache_array` holds the tag, valid and data storage:
  - one combinational read port;
  - one word write port;
  - one tag/valid write port;
  - a synchronous clear of the valid bits on `rst`.
- The FSM, counters and memory-side registers live in `dcache_ctrl`.

## Test plan
- Cold read `addr`=16'h0123 with L=3 → stall high for 13 cycles. Memory sees reads at 0x0120 to 0x0123. `rdata` = memory word at 0x0123. `miss_cnt`=1.
- Read 16'h0121 right after the previous fill → stall=0 the same cycle; `rdata` correct; `hit_cnt`=1; `mem_req` stays 0.
- Store 16'hBEEF to 0x0122 (hit) with L=3 → 4 stall cycles, then DONE with stall=0. Memory is written. A subsequent read of 0x0122 returns 16'hBEEF with no memory access.
- Store to an uncached address 0x4000 → memory is written; `valid` for that index is unchanged; the next read of 0x4000 misses.
- Conflict: read 0x0010 then 0x0810 (same index, different tag) → both miss, and the second fill evicts the first; a read of 0x0010 then misses again.
- Assert `rst` in the 2nd cycle of a FILL → next cycle `mem_req`=0, stall=0, all lines invalid, counters 0. A stray `mem_ack` afterwards causes no state change.
